bubble_sort_ctrl: RTL

Sequencer that sorts a block of N unsigned values with a single compare-and-swap step per cycle.
- Accepts N values serially over a valid/ready stream into an internal register buffer.
- Runs bubble-sort passes, with early exit when a pass makes no swap.
- Streams the sorted block out in ascending order over a valid/ready stream.
- Serial-sort counterpart to the parallel 3-input bottom sorter; it feeds the downstream consumer of the sort project.

---
 rtl/bubble_sort_if.sv | 12 +
 rtl/bubble_sort_ctrl.sv | 95 +++++++++
 2 files changed

// File: rtl/bubble_sort_if.sv
// bubble_sort_if: valid/ready load and drain streams of the bubble sort sequencer
interface bubble_sort_if #(parameter int W = 4);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic [W-1:0] out_data;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_last);
  modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/bubble_sort_ctrl.sv
// bubble_sort_ctrl: loads N values, bubble-sorts them one compare per cycle, streams them out ascending
module bubble_sort_ctrl #(
  parameter int N     = 8,
  parameter int W     = 4,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  bubble_sort_if.slave     bus,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] swap_cnt
);
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_J = IW'(N - 2);
  localparam logic [IW-1:0] LAST_I = IW'(N - 1);
  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;
  state_t        state;
  logic [W-1:0]  mem [N];
  logic [IW-1:0] wr_idx, rd_idx, j, pass;
  logic          swapped;
  logic [IW-1:0] j1, lim;
  logic [W-1:0]  a, b;
  logic          gt;
  // compare pair at j/j+1; the pass shrinks by one element each time since the tail is already final
  always_comb begin
    j1  = j + 1'b1;
    lim = LAST_J - pass;
    a   = mem[j];
    b   = mem[j1];
    gt  = a > b;
  end
  assign bus.in_ready  = state == LOAD;
  assign bus.out_valid = state == DRAIN;
  assign bus.out_data  = mem[rd_idx];
  assign bus.out_last  = state == DRAIN && rd_idx == LAST_I;
  assign busy          = state != LOAD;
  // sequencer: load, sort passes with early exit, drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= LOAD;
      wr_idx   <= '0;
      rd_idx   <= '0;
      j        <= '0;
      pass     <= '0;
      swapped  <= 1'b0;
      swap_cnt <= '0;
      done     <= 1'b0;
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        LOAD: if (bus.in_valid) begin
          mem[wr_idx] <= bus.in_data;
          if (wr_idx == LAST_I) begin
            wr_idx   <= '0;
            swap_cnt <= '0;
            j        <= '0;
            pass     <= '0;
            swapped  <= 1'b0;
            state    <= SORT;
          end else wr_idx <= wr_idx + 1'b1;
        end
        SORT: begin
          if (gt) begin
            mem[j]   <= b;
            mem[j1]  <= a;
            swap_cnt <= swap_cnt + 1'b1;
          end
          if (j != lim) begin
            j       <= j1;
            swapped <= swapped | gt;
          end else if (!(swapped | gt) || pass == LAST_J) begin
            rd_idx <= '0;
            state  <= DRAIN;
          end else begin
            pass    <= pass + 1'b1;
            j       <= '0;
            swapped <= 1'b0;
          end
        end
        DRAIN: if (bus.out_ready) begin
          if (rd_idx == LAST_I) begin
            rd_idx <= '0;
            pass   <= '0;
            j      <= '0;
            done   <= 1'b1;
            state  <= LOAD;
          end else rd_idx <= rd_idx + 1'b1;
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule
